// File: rtl/esfa_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : esfa_arb_pkg
// Description : Shared constants and the state type for the ESFA request
//               arbiter (field width, latency counter width, idle selector).
// Revision    : 1.0 - initial release
// ============================================================================
package esfa_arb_pkg;

  localparam int ESFA_FIELD_W = 8;
  localparam int LAT_CNT_W    = 4;

  // Selector code that the ESFA datapath treats as "no operation".
  localparam logic [ESFA_FIELD_W-1:0] DEFAULT_SEL_IDLE = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } arb_state_e;

endpackage : esfa_arb_pkg
`default_nettype wire

// File: rtl/esfa_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : esfa_rr_picker
// Description : Combinational round-robin picker. Scans the request vector
//               starting one position above the rr pointer (with wrap) and
//               returns the first set request as a one-hot grant and a
//               binary id.
// Revision    : 1.0 - initial release
// Ports       : req_i   - request vector
//               rr_i    - id of the most recent round-robin winner
//               grant_o - one-hot grant (zero when no request)
//               id_o    - binary id of the winner
//               found_o - at least one request present
// ============================================================================
module esfa_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    id_o,
  output logic               found_o
);

  int              w_idx;
  logic [ID_W-1:0] w_sel;

  always_comb begin
    grant_o = '0;
    id_o    = '0;
    found_o = 1'b0;
    w_idx   = 0;
    w_sel   = '0;
    // Offset 1..NUM_REQ so the previous winner is examined last.
    for (int off = 1; off <= NUM_REQ; off++) begin
      w_idx = (int'(rr_i) + off) % NUM_REQ;
      w_sel = ID_W'(w_idx);
      if (!found_o && req_i[w_sel]) begin
        found_o        = 1'b1;
        grant_o[w_sel] = 1'b1;
        id_o           = w_sel;
      end
    end
  end

endmodule : esfa_rr_picker
`default_nettype wire

// File: rtl/esfa_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : esfa_request_arbiter
// Description : Shares one ESFADesign datapath between NUM_REQ requesters.
//               Grants round-robin, issues the winner's op for one cycle,
//               waits RESULT_LATENCY cycles, then returns the sampled result
//               to the winner with a one-cycle rsp_valid strobe.
// Revision    : 1.0 - initial release
// Config      : ESFA_ARB_PRIORITY_EN - when defined, requester 0 has strict
//               priority and the others round-robin among themselves.
// Ports       : clk, reset          - clock, synchronous active-high reset
//               req_*               - per-requester op (valid/ready, packed
//                                     8-bit fields, requester i at [8i+:8])
//               rsp_valid/bool/value- response strobe and captured result
//               esfa_*              - datapath drive and result inputs
//               busy                - arbiter not idle
// ============================================================================
module esfa_request_arbiter
  import esfa_arb_pkg::*;
#(
  parameter int                     NUM_REQ        = 4,
  parameter int                     RESULT_LATENCY = 1,
  parameter logic [ESFA_FIELD_W-1:0] SEL_IDLE      = DEFAULT_SEL_IDLE
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_mutating,
  input  logic [ESFA_FIELD_W*NUM_REQ-1:0] req_handle,
  input  logic [ESFA_FIELD_W*NUM_REQ-1:0] req_index,
  input  logic [ESFA_FIELD_W*NUM_REQ-1:0] req_value,
  input  logic [ESFA_FIELD_W*NUM_REQ-1:0] req_selector,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic                            rsp_bool,
  output logic [ESFA_FIELD_W-1:0]         rsp_value,
  output logic [ESFA_FIELD_W-1:0]         esfa_queried_handle,
  output logic [ESFA_FIELD_W-1:0]         esfa_new_index,
  output logic [ESFA_FIELD_W-1:0]         esfa_new_value,
  output logic [ESFA_FIELD_W-1:0]         esfa_selector,
  input  logic                            esfa_result_bool,
  input  logic [ESFA_FIELD_W-1:0]         esfa_result_value,
  output logic                            busy
);

  localparam int                   ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ID_W-1:0]      RR_RESET = ID_W'(NUM_REQ - 1);
  localparam logic [LAT_CNT_W-1:0] CNT_LOAD = LAT_CNT_W'(RESULT_LATENCY - 1);

  arb_state_e                state_q;
  logic [ID_W-1:0]           rr_q;
  logic [ID_W-1:0]           id_q;
  logic [LAT_CNT_W-1:0]      cnt_q;
  logic [ESFA_FIELD_W-1:0]   esfa_handle_q;
  logic [ESFA_FIELD_W-1:0]   esfa_index_q;
  logic [ESFA_FIELD_W-1:0]   esfa_value_q;
  logic [ESFA_FIELD_W-1:0]   esfa_sel_q;
  logic [NUM_REQ-1:0]        rsp_valid_q;
  logic                      rsp_bool_q;
  logic [ESFA_FIELD_W-1:0]   rsp_value_q;

  logic [NUM_REQ-1:0]        w_pick_req;
  logic [NUM_REQ-1:0]        w_pick_grant;
  logic [ID_W-1:0]           w_pick_id;
  logic                      w_pick_found;
  logic [NUM_REQ-1:0]        w_win_grant;
  logic [ID_W-1:0]           w_win_id;
  logic                      w_win_found;
  logic                      w_rr_update;
  logic                      w_fire;
  logic [ID_W+2:0]           w_base;

  // Mutating ops travel the same issue/wait/respond path as queries; the
  // flag only tells the requester the returned result is not meaningful.
  logic                      w_unused_mutating;
  assign w_unused_mutating = ^req_mutating;

`ifdef ESFA_ARB_PRIORITY_EN
  // Requester 0 is removed from the rotation and overrides it when valid.
  assign w_pick_req = {req_valid[NUM_REQ-1:1], 1'b0};

  always_comb begin
    w_win_grant = w_pick_grant;
    w_win_id    = w_pick_id;
    w_win_found = w_pick_found;
    w_rr_update = 1'b1;
    if (req_valid[0]) begin
      w_win_grant = NUM_REQ'(1);
      w_win_id    = '0;
      w_win_found = 1'b1;
      w_rr_update = 1'b0;
    end
  end
`else
  assign w_pick_req  = req_valid;
  assign w_win_grant = w_pick_grant;
  assign w_win_id    = w_pick_id;
  assign w_win_found = w_pick_found;
  assign w_rr_update = 1'b1;
`endif

  esfa_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req_i   (w_pick_req),
    .rr_i    (rr_q),
    .grant_o (w_pick_grant),
    .id_o    (w_pick_id),
    .found_o (w_pick_found)
  );

  assign w_fire    = (state_q == ST_IDLE) && w_win_found && !reset;
  assign req_ready = w_fire ? w_win_grant : '0;

  // Bit offset of the winner's 8-bit field inside the packed buses.
  assign w_base = {w_win_id, 3'b000};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      rr_q          <= RR_RESET;
      id_q          <= '0;
      cnt_q         <= '0;
      esfa_handle_q <= '0;
      esfa_index_q  <= '0;
      esfa_value_q  <= '0;
      esfa_sel_q    <= SEL_IDLE;
      rsp_valid_q   <= '0;
      rsp_bool_q    <= 1'b0;
      rsp_value_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_fire) begin
            esfa_handle_q <= req_handle[w_base +: ESFA_FIELD_W];
            esfa_index_q  <= req_index[w_base +: ESFA_FIELD_W];
            esfa_value_q  <= req_value[w_base +: ESFA_FIELD_W];
            esfa_sel_q    <= req_selector[w_base +: ESFA_FIELD_W];
            id_q          <= w_win_id;
            if (w_rr_update) begin
              rr_q <= w_win_id;
            end
            state_q <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Selector is live for the issue cycle only; operands stay put.
          esfa_sel_q <= SEL_IDLE;
          cnt_q      <= CNT_LOAD;
          state_q    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt_q == '0) begin
            rsp_bool_q  <= esfa_result_bool;
            rsp_value_q <= esfa_result_value;
            rsp_valid_q <= NUM_REQ'(1) << id_q;
            state_q     <= ST_RESPOND;
          end else begin
            cnt_q <= cnt_q - LAT_CNT_W'(1);
          end
        end
        ST_RESPOND: begin
          rsp_valid_q <= '0;
          state_q     <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign esfa_queried_handle = esfa_handle_q;
  assign esfa_new_index      = esfa_index_q;
  assign esfa_new_value      = esfa_value_q;
  assign esfa_selector       = esfa_sel_q;
  assign rsp_valid           = rsp_valid_q;
  assign rsp_bool            = rsp_bool_q;
  assign rsp_value           = rsp_value_q;
  assign busy                = (state_q != ST_IDLE);

endmodule : esfa_request_arbiter
`default_nettype wire

// File: tb/tb_esfa_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_esfa_request_arbiter
// Description : Self-checking bench for esfa_request_arbiter. A transaction
//               level model predicts grants, datapath drive and responses;
//               expected responses are queued and a monitor compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_esfa_request_arbiter;

  localparam int          N        = 4;
  localparam int          LAT      = 3;
  localparam logic [7:0]  SEL_IDLE_TB = 8'h00;
  localparam int          HIST     = 4096;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_mutating = '0;
  logic [8*N-1:0] req_handle = '0;
  logic [8*N-1:0] req_index = '0;
  logic [8*N-1:0] req_value = '0;
  logic [8*N-1:0] req_selector = '0;
  logic           esfa_result_bool = 1'b0;
  logic [7:0]     esfa_result_value = '0;

  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic           rsp_bool;
  logic [7:0]     rsp_value;
  logic [7:0]     esfa_queried_handle;
  logic [7:0]     esfa_new_index;
  logic [7:0]     esfa_new_value;
  logic [7:0]     esfa_selector;
  logic           busy;

  esfa_request_arbiter #(
    .NUM_REQ        (N),
    .RESULT_LATENCY (LAT),
    .SEL_IDLE       (SEL_IDLE_TB)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_mutating        (req_mutating),
    .req_handle          (req_handle),
    .req_index           (req_index),
    .req_value           (req_value),
    .req_selector        (req_selector),
    .rsp_valid           (rsp_valid),
    .rsp_bool            (rsp_bool),
    .rsp_value           (rsp_value),
    .esfa_queried_handle (esfa_queried_handle),
    .esfa_new_index      (esfa_new_index),
    .esfa_new_value      (esfa_new_value),
    .esfa_selector       (esfa_selector),
    .esfa_result_bool    (esfa_result_bool),
    .esfa_result_value   (esfa_result_value),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Datapath result history, one entry per cycle.
  logic [7:0] hist_val  [HIST];
  logic       hist_bool [HIST];

  typedef struct {
    int id;
    int rsp_cyc;
    int samp_cyc;
  } exp_t;
  exp_t sb[$];

  // ---------------- reference model ----------------
  int           m_rr = N - 1;
  int           m_free = 0;
  int           m_iss_cyc = -1;
  logic [7:0]   m_iss_h, m_iss_i, m_iss_v, m_iss_s;
  logic [7:0]   m_hold_h = '0, m_hold_i = '0, m_hold_v = '0;
  logic [N-1:0] fired = '0;

  function automatic int pick(input logic [N-1:0] v, input int rr);
`ifdef ESFA_ARB_PRIORITY_EN
    if (v[0]) return 0;
    v[0] = 1'b0;
`endif
    for (int k = 1; k <= N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int           w;
    bit           idle;
    if (reset) begin
      sb.delete();
      m_rr      = N - 1;
      m_free    = cyc + 1;
      m_iss_cyc = -1;
      m_hold_h  = '0;
      m_hold_i  = '0;
      m_hold_v  = '0;
      fired     = '0;
    end else begin
      if (cyc == m_iss_cyc) begin
        m_hold_h = m_iss_h;
        m_hold_i = m_iss_i;
        m_hold_v = m_iss_v;
      end
      idle      = (cyc >= m_free);
      exp_ready = '0;
      fired     = '0;
      if (idle) begin
        w = pick(req_valid, m_rr);
        if (w >= 0) begin
          exp_ready[w] = 1'b1;
          fired[w]     = 1'b1;
          sb.push_back('{id: w, rsp_cyc: cyc + LAT + 2, samp_cyc: cyc + 1 + LAT});
          m_iss_cyc = cyc + 1;
          m_iss_h   = req_handle[w*8 +: 8];
          m_iss_i   = req_index[w*8 +: 8];
          m_iss_v   = req_value[w*8 +: 8];
          m_iss_s   = req_selector[w*8 +: 8];
          m_free    = cyc + LAT + 3;
`ifdef ESFA_ARB_PRIORITY_EN
          if (w != 0) m_rr = w;
`else
          m_rr = w;
`endif
        end
      end
      chk(req_ready == exp_ready, "req_ready", req_ready, exp_ready);
      chk(busy == !idle, "busy", busy, !idle);
      chk(esfa_selector == ((cyc == m_iss_cyc) ? m_iss_s : SEL_IDLE_TB), "esfa_selector",
          esfa_selector, (cyc == m_iss_cyc) ? m_iss_s : SEL_IDLE_TB);
      chk(esfa_queried_handle == m_hold_h, "esfa_handle", esfa_queried_handle, m_hold_h);
      chk(esfa_new_index == m_hold_i, "esfa_index", esfa_new_index, m_hold_i);
      chk(esfa_new_value == m_hold_v, "esfa_value", esfa_new_value, m_hold_v);
    end
  end

  // ---------------- response monitor ----------------
  exp_t e;
  always @(negedge clk) begin
    logic [N-1:0] exp_rv;
    if (!reset) begin
      exp_rv = '0;
      if (sb.size() > 0 && sb[0].rsp_cyc == cyc) begin
        e = sb.pop_front();
        exp_rv[e.id] = 1'b1;
        chk(rsp_value == hist_val[e.samp_cyc % HIST], "rsp_value", rsp_value, hist_val[e.samp_cyc % HIST]);
        chk(rsp_bool == hist_bool[e.samp_cyc % HIST], "rsp_bool", rsp_bool, hist_bool[e.samp_cyc % HIST]);
      end
      chk(rsp_valid == exp_rv, "rsp_valid", rsp_valid, exp_rv);
    end
  end

  // ---------------- stimulus ----------------
  // 0: no new ops, 1: all requesters continuously, 2: random,
  // 3: continuous on requesters 1..N-1 only
  int mode = 0;

  task automatic new_op(input int i);
    req_valid[i]           = 1'b1;
    req_mutating[i]        = 1'($urandom);
    req_handle[i*8 +: 8]   = 8'($urandom);
    req_index[i*8 +: 8]    = 8'($urandom);
    req_value[i*8 +: 8]    = 8'($urandom);
    req_selector[i*8 +: 8] = 8'($urandom_range(1, 255));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (fired[i]) req_valid[i] = 1'b0;
      case (mode)
        1: if (!req_valid[i]) new_op(i);
        2: begin
          if (!req_valid[i]) begin
            if ($urandom_range(0, 3) == 0) new_op(i);
          end else if ($urandom_range(0, 15) == 0) begin
            req_valid[i] = 1'b0;
          end
        end
        3: begin
          if (i == 0) req_valid[i] = 1'b0;
          else if (!req_valid[i]) new_op(i);
        end
        default: ;
      endcase
    end
    esfa_result_value = 8'($urandom);
    esfa_result_bool  = 1'($urandom);
    hist_val[cyc % HIST]  = esfa_result_value;
    hist_bool[cyc % HIST] = esfa_result_bool;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    bit got2;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk(rsp_value == 8'h00, "reset_rsp_value", rsp_value, 8'h00);
    chk(rsp_bool == 1'b0, "reset_rsp_bool", rsp_bool, 1'b0);

    // Single requester op
    step();
    req_valid[0]      = 1'b1;
    req_mutating[0]   = 1'b0;
    req_handle[7:0]   = 8'h05;
    req_index[7:0]    = 8'h11;
    req_value[7:0]    = 8'h22;
    req_selector[7:0] = 8'h02;
    repeat (LAT + 5) step();

    // Mutating op from requester 1
    req_valid[1]       = 1'b1;
    req_mutating[1]    = 1'b1;
    req_handle[15:8]   = 8'h33;
    req_index[15:8]    = 8'h44;
    req_value[15:8]    = 8'h55;
    req_selector[15:8] = 8'h01;
    repeat (LAT + 5) step();

    // All requesters continuously from reset
    do_reset();
    mode = 1;
    repeat (20) step();

    // Reset during requester 2's WAIT
`ifdef ESFA_ARB_PRIORITY_EN
    mode = 3;
`endif
    got2 = 1'b0;
    for (int k = 0; k < 60 && !got2; k++) begin
      step();
      if (fired[2]) got2 = 1'b1;
    end
    chk(got2, "grant_req2_seen", got2, 1'b1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk(rsp_value == 8'h00, "midop_rsp_value", rsp_value, 8'h00);
    chk(rsp_bool == 1'b0, "midop_rsp_bool", rsp_bool, 1'b0);
    mode = 1;
    repeat (30) step();

    // Random traffic
    mode = 2;
    repeat (400) step();

    // Drain
    mode = 0;
    for (int k = 0; k < 200; k++) begin
      if (req_valid == '0 && sb.size() == 0 && !busy) break;
      step();
    end
    chk(sb.size() == 0, "drain_queue_empty", sb.size(), 0);
    chk(req_valid == '0, "drain_requests_served", req_valid, '0);
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_esfa_request_arbiter
`default_nettype wire

// File: doc/esfa_request_arbiter.md
Name: esfa_request_arbiter

Overview:
- Shares one ESFADesign datapath instance between NUM_REQ independent requesters.
- Each requester presents an op (handle, index, value, selector, mutating flag) via valid/ready.
- The arbiter grants round-robin, issues the op for exactly one cycle, waits the datapath's fixed result latency, then returns resultBool/resultValue to the granted requester.
- Sits between test/host masters and ESFADesign, in place of a single hard-wired driver.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- RESULT_LATENCY, 1, cycles from the issue cycle to the cycle the ESFA result is valid (1..15).
- SEL_IDLE, 8'h00, selector code driven to ESFA when no op is issued (no-op encoding).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- req_valid  in  NUM_REQ  per-requester op valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_mutating  in  NUM_REQ  1 = mutating op (no result check needed, ack only)
- req_handle  in  8*NUM_REQ  packed queried_handle, requester i at [8i+7:8i]
- req_index  in  8*NUM_REQ  packed new_index
- req_value  in  8*NUM_REQ  packed new_value
- req_selector  in  8*NUM_REQ  packed selector
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response strobe
- rsp_bool  out  1  captured resultBool (valid with rsp_valid)
- rsp_value  out  8  captured resultValue (valid with rsp_valid)
- esfa_queried_handle  out  8  to ESFADesign
- esfa_new_index  out  8  to ESFADesign
- esfa_new_value  out  8  to ESFADesign
- esfa_selector  out  8  to ESFADesign
- esfa_result_bool  in  1  from ESFADesign
- esfa_result_value  in  8  from ESFADesign
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous, active-high. All state updates on posedge clk.
- Reset state and outputs:
  - State = IDLE; rr pointer = NUM_REQ-1, so requester 0 wins first.
  - req_ready = 0, rsp_valid = 0, rsp_bool = 0, rsp_value = 0, busy = 0.
  - esfa_selector = SEL_IDLE; other esfa_* = 0.
- IDLE:
  - req_ready is combinational: one-hot at the winner = first asserted req_valid scanning from rr+1 upward with wrap.
  - Handshake fires when req_valid[i] && req_ready[i]. On that edge: capture the winner's fields and id, rr = winner, next state ISSUE.
  - If no valid: stay in IDLE, req_ready = 0.
- ISSUE (1 cycle):
  - esfa_* = captured fields; req_ready = 0.
  - Next state: WAIT, loading the counter with RESULT_LATENCY-1.
- WAIT:
  - esfa_selector = SEL_IDLE; handle/index/value hold their captured values.
  - Counter decrements; at 0, sample esfa_result_bool/value into rsp_bool/rsp_value; next state RESPOND.
  - With RESULT_LATENCY=1, WAIT lasts exactly 1 cycle.
- RESPOND (1 cycle):
  - rsp_valid[id] = 1; rsp_bool/rsp_value hold the sampled result.
  - Mutating ops also respond; their result fields are don't-care to the requester but are still the sampled values.
  - Next state IDLE. rsp_bool/rsp_value hold until the next sample.
- Timing: req_ready is never asserted outside IDLE. Handshake-to-rsp_valid latency = RESULT_LATENCY+2 cycles. Peak throughput = one op per RESULT_LATENCY+3 cycles.
- Requester dropping req_valid before handshake: legal; no grant. Fields are only sampled at the handshake edge.
- Simultaneous requests: exactly one granted per IDLE cycle. The others wait; no starvation, since every requester is granted within NUM_REQ grants.
- Reset mid-operation (ISSUE/WAIT/RESPOND): the op is dropped silently, no rsp_valid is emitted, and everything returns to the reset state the next cycle.
- Counter width: 4 bits.
- Packed-bus slicing uses constant-width indexed part-selects.

Optional Feature:
- Macro: ESFA_ARB_PRIORITY_EN.
- Defined: requester 0 has strict priority. If req_valid[0] is high in IDLE it wins regardless of rr, and rr is not updated on a requester-0 grant. Requesters 1..NUM_REQ-1 round-robin among themselves.
- Undefined: pure round-robin over all requesters as above.

Decomposition:
- Package esfa_arb_pkg holds:
  - state encoding constants ST_IDLE=0, ST_ISSUE=1, ST_WAIT=2, ST_RESPOND=3 (2 bits);
  - ESFA_FIELD_W=8;
  - LAT_CNT_W=4;
  - default SEL_IDLE.
- Sub-module esfa_rr_picker: purely combinational. Inputs: request vector and rr pointer. Outputs: one-hot grant and binary winner id. Reused by the priority variant with the bit-0 override applied outside it.

Test Plan:
- Single requester: req_valid=4'b0001 at cycle 0, handle=8'h05, sel=8'h02, RESULT_LATENCY=1.
  - Expected: req_ready[0] at cycle 0; esfa_selector=8'h02 for exactly cycle 1 only.
  - Expected: esfa_result_value=8'h2A present at cycle 2 gives rsp_valid=4'b0001 with rsp_value=8'h2A at cycle 3.
- All four valid continuously from reset: grant order 0,1,2,3,0.
  - Expected: each rsp_valid pulse arrives 3 cycles after its grant; no overlapping grants.
- RESULT_LATENCY=3:
  - Expected: rsp_valid arrives 5 cycles after the handshake, and rsp_value equals the ESFA output sampled exactly 3 cycles after the issue cycle, not adjacent cycles.
- Reset during WAIT: assert reset 1 cycle during requester 2's WAIT.
  - Expected: no rsp_valid; outputs are zero and esfa_selector=SEL_IDLE on the next cycle; the next grant goes to requester 0.
- With ESFA_ARB_PRIORITY_EN, req_valid=4'b1111 held:
  - Expected: requester 0 granted on every IDLE cycle.
  - Expected: after req_valid[0] drops, grants go 1,2,3 in order.
- Mutating op: req_mutating[1]=1, sel=8'h01.
  - Expected: the op is issued for one cycle, and rsp_valid[1] pulses once at handshake+3.
